// File: rtl/timer_pkg.sv
// Shared definitions for the system-bus timer: register offsets, mode encoding
// and bus widths.
package timer_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        NTIMES  = 2'd1,
        FOREVER = 2'd2
    } timer_mode_e;

    localparam logic [ADDR_W-1:0] ADDR_SYSTEM_COUNTER = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] ADDR_DELAY          = 32'h0000_0004;
    localparam logic [ADDR_W-1:0] ADDR_MODE           = 32'h0000_0008;
    localparam logic [ADDR_W-1:0] ADDR_REPEAT_COUNTER = 32'h0000_000C;
    localparam logic [ADDR_W-1:0] ADDR_RESET          = 32'h0000_0024;

    localparam logic [BUS_W-1:0] RESET_CMD = 32'd1;

    // The unused encoding 3 collapses to OFF.
    function automatic timer_mode_e decode_mode(input logic [1:0] raw);
        timer_mode_e mode;
        case (raw)
            2'd1:    mode = NTIMES;
            2'd2:    mode = FOREVER;
            default: mode = OFF;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/timer_sb_ctrl.sv
// Memory-mapped timer: free-running cycle counter plus a periodic / N-shot
// countdown raising a sticky level interrupt. Single-beat bus, 1-cycle latency.
module timer_sb_ctrl
    import timer_pkg::*;
#(
    parameter int unsigned DELAY_WIDTH = 32
) (
    input  logic              sys_clk_i,
    input  logic              sys_areset_n_i,
    input  logic              req_i,
    input  logic              write_enable_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [BUS_W-1:0]  write_data_i,
    output logic [BUS_W-1:0]  read_data_o,
    output logic              ready_o,
    output logic              interrupt_request_o,
    input  logic              interrupt_return_i
);

    logic [BUS_W-1:0]       system_counter_q, system_counter_d;
    logic [DELAY_WIDTH-1:0] delay_q, delay_d;
    logic [DELAY_WIDTH-1:0] period_cnt_q, period_cnt_d;
    timer_mode_e            mode_q, mode_d;
    logic [BUS_W-1:0]       repeat_counter_q, repeat_counter_d;
    logic                   irq_q, irq_d;
    logic [BUS_W-1:0]       read_data_d;
    logic                   ready_d;

    logic wr_c;
    logic rd_c;
    logic timer_active_c;
    logic count_en_c;
    logic expire_c;

    assign wr_c = req_i & write_enable_i;
    assign rd_c = req_i & ~write_enable_i;

    // An NTIMES timer with no repeats left is parked, not counting.
    assign timer_active_c = (mode_q == FOREVER) ||
                            ((mode_q == NTIMES) && (repeat_counter_q != '0));
    assign count_en_c     = timer_active_c && (delay_q != '0);
    assign expire_c       = count_en_c && (period_cnt_q == (delay_q - DELAY_WIDTH'(1)));

    // Next-state: countdown first, then bus writes override, reset command last.
    always_comb begin
        system_counter_d = system_counter_q + BUS_W'(1);
        delay_d          = delay_q;
        period_cnt_d     = period_cnt_q;
        mode_d           = mode_q;
        repeat_counter_d = repeat_counter_q;
        irq_d            = irq_q & ~interrupt_return_i;
        read_data_d      = '0;
        ready_d          = req_i;

        if (expire_c) begin
            period_cnt_d = '0;
            irq_d        = 1'b1;
            if (mode_q == NTIMES) begin
                repeat_counter_d = repeat_counter_q - BUS_W'(1);
                if (repeat_counter_q == BUS_W'(1)) begin
                    mode_d = OFF;
                end
            end
        end else if (count_en_c) begin
            period_cnt_d = period_cnt_q + DELAY_WIDTH'(1);
        end

        if ((mode_q == NTIMES) && (repeat_counter_q == '0)) begin
            mode_d = OFF;
        end

        if (wr_c) begin
            case (addr_i)
                ADDR_DELAY: begin
                    delay_d      = DELAY_WIDTH'(write_data_i);
                    period_cnt_d = '0;
                end
                ADDR_MODE: begin
                    mode_d       = decode_mode(write_data_i[1:0]);
                    period_cnt_d = '0;
                end
                ADDR_REPEAT_COUNTER: begin
                    repeat_counter_d = write_data_i;
                end
                ADDR_RESET: begin
                    if ((write_data_i & RESET_CMD) != '0) begin
                        system_counter_d = '0;
                        delay_d          = '0;
                        period_cnt_d     = '0;
                        mode_d           = OFF;
                        repeat_counter_d = '0;
                        irq_d            = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        if (rd_c) begin
            case (addr_i)
                ADDR_SYSTEM_COUNTER: read_data_d = system_counter_q;
                ADDR_DELAY:          read_data_d = BUS_W'(delay_q);
                ADDR_MODE:           read_data_d = BUS_W'(mode_q);
                ADDR_REPEAT_COUNTER: read_data_d = repeat_counter_q;
                default:             read_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i or negedge sys_areset_n_i) begin
        if (!sys_areset_n_i) begin
            system_counter_q <= '0;
            delay_q          <= '0;
            period_cnt_q     <= '0;
            mode_q           <= OFF;
            repeat_counter_q <= '0;
            irq_q            <= 1'b0;
            read_data_o      <= '0;
            ready_o          <= 1'b0;
        end else begin
            system_counter_q <= system_counter_d;
            delay_q          <= delay_d;
            period_cnt_q     <= period_cnt_d;
            mode_q           <= mode_d;
            repeat_counter_q <= repeat_counter_d;
            irq_q            <= irq_d;
            read_data_o      <= read_data_d;
            ready_o          <= ready_d;
        end
    end

    assign interrupt_request_o = irq_q;

endmodule

// File: tb/tb_timer_sb_ctrl.sv
// Directed self-checking bench for timer_sb_ctrl.
module tb_timer_sb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        irq;
    logic        ret = 1'b0;

    int n_checks = 0;
    int n_passed = 0;

    timer_sb_ctrl #(.DELAY_WIDTH(32)) dut (
        .sys_clk_i           (clk),
        .sys_areset_n_i      (rst_n),
        .req_i               (req),
        .write_enable_i      (we),
        .addr_i              (addr),
        .write_data_i        (wdata),
        .read_data_o         (rdata),
        .ready_o             (ready),
        .interrupt_request_o (irq),
        .interrupt_return_i  (ret)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
        check("wr_ready", 32'(ready), 32'd1);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        tick();
        check("rd_ready", 32'(ready), 32'd1);
        d = rdata;
        req = 1'b0;
    endtask

    task automatic cycles_to_irq(input int limit, output int n);
        n = 0;
        while (!irq && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic ret_pulse();
        ret = 1'b1;
        tick();
        ret = 1'b0;
    endtask

    logic [31:0] v, v2;
    int n;

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        tick();
        bus_read(32'h08, v);
        check("rst_mode", v, 32'd0);
        tick();
        check("ready_pulse", 32'(ready), 32'd0);

        // back-to-back system_counter reads
        req = 1'b1; we = 1'b0; addr = 32'h00;
        tick();
        v = rdata;
        check("b2b_ready0", 32'(ready), 32'd1);
        tick();
        v2 = rdata;
        check("b2b_ready1", 32'(ready), 32'd1);
        req = 1'b0;
        check("sysctr_step", v2 - v, 32'd1);

        // unmapped / write-only addresses
        bus_read(32'h24, v);
        check("rd_reset_reg", v, 32'd0);
        bus_write(32'h10, 32'hDEAD_BEEF);
        bus_read(32'h10, v);
        check("rd_unmapped", v, 32'd0);

        // FOREVER, delay 5
        bus_write(32'h04, 32'd5);
        bus_read(32'h04, v);
        check("rd_delay", v, 32'd5);
        bus_write(32'h08, 32'd2);
        cycles_to_irq(20, n);
        check("forever_first", 32'(n), 32'd5);
        ret_pulse();
        check("irq_cleared", 32'(irq), 32'd0);
        cycles_to_irq(20, n);
        check("forever_second", 32'(n), 32'd4);

        // return in the same cycle as expiry: set wins
        ret_pulse();
        check("irq_cleared2", 32'(irq), 32'd0);
        repeat (3) tick();
        check("pre_expiry", 32'(irq), 32'd0);
        ret = 1'b1;
        tick();
        ret = 1'b0;
        check("ret_vs_expire", 32'(irq), 32'd1);

        // reset command coincident with the next expiry
        ret_pulse();
        repeat (3) tick();
        bus_write(32'h24, 32'd1);
        check("rstcmd_irq", 32'(irq), 32'd0);
        bus_read(32'h00, v);
        check("rstcmd_sysctr", v, 32'd0);
        bus_read(32'h04, v);
        check("rstcmd_delay", v, 32'd0);
        bus_read(32'h08, v);
        check("rstcmd_mode", v, 32'd0);
        bus_read(32'h0C, v);
        check("rstcmd_repeat", v, 32'd0);
        repeat (10) tick();
        check("rstcmd_quiet", 32'(irq), 32'd0);

        // NTIMES: delay 3, two repeats
        bus_write(32'h04, 32'd3);
        bus_write(32'h0C, 32'd2);
        bus_write(32'h08, 32'd1);
        cycles_to_irq(20, n);
        check("ntimes_first", 32'(n), 32'd3);
        ret_pulse();
        check("ntimes_clr", 32'(irq), 32'd0);
        cycles_to_irq(20, n);
        check("ntimes_second", 32'(n), 32'd2);
        bus_read(32'h08, v);
        check("ntimes_mode_off", v, 32'd0);
        bus_read(32'h0C, v);
        check("ntimes_repeat0", v, 32'd0);
        ret_pulse();
        repeat (10) tick();
        check("ntimes_no_third", 32'(irq), 32'd0);

        // NTIMES with zero repeats, and mode 3
        bus_write(32'h08, 32'd1);
        tick();
        bus_read(32'h08, v);
        check("ntimes0_mode", v, 32'd0);
        check("ntimes0_irq", 32'(irq), 32'd0);
        bus_write(32'h08, 32'd3);
        bus_read(32'h08, v);
        check("mode3_off", v, 32'd0);

        // delay 0 never expires and keeps mode
        bus_write(32'h04, 32'd0);
        bus_write(32'h08, 32'd2);
        repeat (10) tick();
        check("delay0_irq", 32'(irq), 32'd0);
        bus_read(32'h08, v);
        check("delay0_mode", v, 32'd2);

        // asynchronous reset mid-count
        bus_write(32'h24, 32'd1);
        bus_write(32'h04, 32'd100);
        bus_write(32'h08, 32'd2);
        repeat (20) tick();
        bus_read(32'h04, v);
        check("pre_async_rd", v, 32'd100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rdata", rdata, 32'd0);
        check("async_ready", 32'(ready), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        bus_read(32'h04, v);
        check("post_async_delay", v, 32'd0);
        bus_read(32'h08, v);
        check("post_async_mode", v, 32'd0);
        repeat (110) tick();
        check("post_async_irq", 32'(irq), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
